sv_bus_mux_demux_demux: RTL and testbench

Stream-to-bus deserializer: the receive end of the byte-stream link driven by the bus-to-stream mux. Collects 8-byte packets from the `str_*` handshake, reassembles each into one 32-bit address plus 32-bit data bus write, and presents it on a valid/ready bus port. A full assembly buffer plus an output register give double buffering, so the stream side keeps running while the bus side holds a word.

---
 rtl/sv_bus_mux_demux_demux.sv | 94 +++++++++
 tb/tb_sv_bus_mux_demux_demux.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/sv_bus_mux_demux_demux.sv
// rtl/sv_bus_mux_demux_demux.sv - byte stream to 32-bit address/data bus write deserializer
module sv_bus_mux_demux_demux (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        str_vld,
  input  logic [7:0]  str_bus,
  output logic        str_rdy,
  output logic        bus_vld,
  output logic [31:0] bus_adr,
  output logic [31:0] bus_dat,
  input  logic        bus_rdy
);

  logic [2:0]  cnt_q, cnt_d;
  logic [55:0] asm_q, asm_d;
  logic        asm_full_q, asm_full_d;
  logic [63:0] full_q, full_d;
  logic        bus_vld_q, bus_vld_d;
  logic [63:0] out_q, out_d;

  logic        byte_acc;
  logic        bus_xfer;
  logic        pkt_done;
  logic [63:0] new_pkt;

  // Handshakes and the packet formed by the stored lanes plus the incoming last byte
  always_comb begin
    byte_acc = str_vld & ~asm_full_q;
    bus_xfer = bus_vld_q & bus_rdy;
    pkt_done = byte_acc & (cnt_q == 3'd7);
    new_pkt  = {str_bus, asm_q};
  end

  // Next-state: byte collection, packet completion, and output/assembly hand-off
  always_comb begin
    cnt_d      = cnt_q;
    asm_d      = asm_q;
    asm_full_d = asm_full_q;
    full_d     = full_q;
    bus_vld_d  = bus_vld_q;
    out_d      = out_q;

    if (byte_acc) begin
      cnt_d = cnt_q + 3'd1;
      for (int k = 0; k < 7; k++) begin
        if (cnt_q == 3'(k)) asm_d[k*8 +: 8] = str_bus;
      end
    end

    if (pkt_done) begin
      if (!bus_vld_q || bus_xfer) begin
        out_d     = new_pkt;
        bus_vld_d = 1'b1;
      end else begin
        full_d     = new_pkt;
        asm_full_d = 1'b1;
      end
    end

    // A completing byte cannot coincide with asm_full, so the two branches never collide
    if (bus_xfer && asm_full_q) begin
      out_d      = full_q;
      bus_vld_d  = 1'b1;
      asm_full_d = 1'b0;
    end else if (bus_xfer && !pkt_done) begin
      bus_vld_d = 1'b0;
    end
  end

  // State registers; reset drops any partial or buffered packet
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= 3'd0;
      asm_q      <= 56'd0;
      asm_full_q <= 1'b0;
      full_q     <= 64'd0;
      bus_vld_q  <= 1'b0;
      out_q      <= 64'd0;
    end else begin
      cnt_q      <= cnt_d;
      asm_q      <= asm_d;
      asm_full_q <= asm_full_d;
      full_q     <= full_d;
      bus_vld_q  <= bus_vld_d;
      out_q      <= out_d;
    end
  end

  assign str_rdy = ~asm_full_q;
  assign bus_vld = bus_vld_q;
  assign bus_adr = out_q[63:32];
  assign bus_dat = out_q[31:0];

endmodule

// File: tb/tb_sv_bus_mux_demux_demux.sv
// tb/tb_sv_bus_mux_demux_demux.sv - randomized scoreboard bench for the stream-to-bus deserializer
module tb_sv_bus_mux_demux_demux;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        str_vld = 1'b0;
  logic [7:0]  str_bus = 8'd0;
  logic        str_rdy;
  logic        bus_vld;
  logic [31:0] bus_adr;
  logic [31:0] bus_dat;
  logic        bus_rdy = 1'b0;

  int vectors = 0;
  int miscompares = 0;
  bit chk_en = 1'b0;
  int acc_cnt = 0;

  // Model: bytes of the packet in progress, and completed packets not yet taken by the bus
  logic [7:0]  part[$];
  logic [63:0] pend[$];

  sv_bus_mux_demux_demux dut (
    .clk(clk), .rst_n(rst_n), .str_vld(str_vld), .str_bus(str_bus), .str_rdy(str_rdy),
    .bus_vld(bus_vld), .bus_adr(bus_adr), .bus_dat(bus_dat), .bus_rdy(bus_rdy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare process: DUT outputs against the model every cycle, mid-cycle
  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_str_rdy", 64'(str_rdy), 64'(pend.size() < 2));
      chk("model_bus_vld", 64'(bus_vld), 64'(pend.size() > 0));
      if (pend.size() > 0) begin
        chk("model_bus_adr", 64'(bus_adr), 64'(pend[0][63:32]));
        chk("model_bus_dat", 64'(bus_dat), 64'(pend[0][31:0]));
      end
    end
  end

  // One clock with the given inputs; the model advances with the same edge
  task automatic step(input logic v, input logic [7:0] b, input logic r);
    bit acc, xfer;
    logic [63:0] p;
    str_vld = v;
    str_bus = b;
    bus_rdy = r;
    if (v && str_rdy) acc_cnt++;
    acc  = v && (pend.size() < 2);
    xfer = r && (pend.size() > 0);
    @(posedge clk);
    if (xfer) void'(pend.pop_front());
    if (acc) begin
      part.push_back(b);
      if (part.size() == 8) begin
        for (int k = 0; k < 8; k++) p[k*8 +: 8] = part[k];
        pend.push_back(p);
        part.delete();
      end
    end
    #1;
  endtask

  // Asynchronous reset dropped between edges; outputs must clear without a clock
  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    part.delete();
    pend.delete();
    #1;
    chk("rst_bus_vld", 64'(bus_vld), 64'd0);
    chk("rst_bus_adr", 64'(bus_adr), 64'd0);
    chk("rst_bus_dat", 64'(bus_dat), 64'd0);
    chk("rst_str_rdy", 64'(str_rdy), 64'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #1;
    chk("init_str_rdy", 64'(str_rdy), 64'd1);
    chk("init_bus_vld", 64'(bus_vld), 64'd0);
    chk("init_bus_adr", 64'(bus_adr), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk_en = 1'b1;

    // Single packet 0x01..0x08
    for (int i = 0; i < 8; i++) step(1'b1, 8'(i + 1), 1'b1);
    chk("single_vld", 64'(bus_vld), 64'd1);
    chk("single_adr", 64'(bus_adr), 64'h08070605);
    chk("single_dat", 64'(bus_dat), 64'h04030201);
    step(1'b0, 8'd0, 1'b1);
    chk("single_vld_drop", 64'(bus_vld), 64'd0);

    // Streaming 24 bytes, bus always ready
    for (int i = 0; i < 24; i++) begin
      chk("stream_str_rdy", 64'(str_rdy), 64'd1);
      step(1'b1, 8'($urandom), 1'b1);
    end
    step(1'b0, 8'd0, 1'b1);

    // Back-pressure: A = 0x11..0x18, B = 0x21..0x28, C offered but refused
    acc_cnt = 0;
    for (int i = 0; i < 24; i++) step(1'b1, 8'(8'h11 + 8'((i / 8) * 16) + 8'(i % 8)), 1'b0);
    chk("bp_accepted", 64'(acc_cnt), 64'd16);
    chk("bp_str_rdy", 64'(str_rdy), 64'd0);
    chk("bp_a_vld", 64'(bus_vld), 64'd1);
    chk("bp_a_adr", 64'(bus_adr), 64'h18171615);
    chk("bp_a_dat", 64'(bus_dat), 64'h14131211);
    step(1'b0, 8'd0, 1'b1);
    chk("bp_b_vld", 64'(bus_vld), 64'd1);
    chk("bp_b_adr", 64'(bus_adr), 64'h28272625);
    chk("bp_b_dat", 64'(bus_dat), 64'h24232221);
    chk("bp_str_rdy_back", 64'(str_rdy), 64'd1);
    step(1'b0, 8'd0, 1'b1);

    // Random bubbles and random bus back-pressure
    for (int i = 0; i < 800; i++)
      step(1'b1 && ($urandom_range(3) != 0), 8'($urandom), ($urandom_range(2) != 0));
    repeat (3) step(1'b0, 8'd0, 1'b1);

    // Leave a word in the output register, then reset mid-packet
    for (int i = 0; i < 8; i++) step(1'b1, 8'(8'h51 + 8'(i)), 1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h61 + 8'(i)), 1'b0);
    do_reset();
    for (int i = 0; i < 8; i++) step(1'b1, 8'(8'hA0 + 8'(i)), 1'b1);
    chk("post_rst_vld", 64'(bus_vld), 64'd1);
    chk("post_rst_adr", 64'(bus_adr), 64'hA7A6A5A4);
    chk("post_rst_dat", 64'(bus_dat), 64'hA3A2A1A0);
    step(1'b0, 8'd0, 1'b1);
    chk("post_rst_one_word", 64'(bus_vld), 64'd0);

    // Reset with both buffers full
    for (int i = 0; i < 16; i++) step(1'b1, 8'($urandom), 1'b0);
    chk("full_str_rdy", 64'(str_rdy), 64'd0);
    chk("full_bus_vld", 64'(bus_vld), 64'd1);
    do_reset();
    repeat (4) step(1'b0, 8'd0, 1'b1);
    chk("full_rst_lost", 64'(bus_vld), 64'd0);

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
